// File: rtl/flex_serial_tx_if.sv
// Word handshake and serial line bundle for flex_serial_tx.
interface flex_serial_tx_if #(
  parameter int NUM_BITS = 8
);
  logic [NUM_BITS-1:0] tx_data;
  logic                tx_valid;
  logic                tx_ready;
  logic                serial_out;
  logic                busy;
  logic                tx_done;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  serial_out,
    input  busy,
    input  tx_done
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output serial_out,
    output busy,
    output tx_done
  );
endinterface

// File: rtl/flex_serial_tx.sv
// Parameterised serial transmitter: start bit, NUM_BITS data bits, optional
// parity, 1 or 2 stop bits, each bit held CLKS_PER_BIT cycles.
//
// state  | meaning
// IDLE   | line high, tx_ready=1, waiting for tx_valid
// START  | driving the start bit (0)
// DATA   | shifting out the captured word
// PARITY | driving the parity bit (PARITY_MODE != 0 only)
// STOP   | driving STOP_BITS stop bits (1)
module flex_serial_tx #(
  parameter int NUM_BITS     = 8,
  parameter int SHIFT_MSB    = 0,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input logic            clk,
  input logic            n_rst,
  flex_serial_tx_if.slave bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(NUM_BITS + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(NUM_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  logic [2:0]          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [NUM_BITS-1:0] shift_q, shift_d;
  logic                par_q, par_d;
  logic                serial_q, serial_d;
  logic                done_q, done_d;
  logic                ready_q, ready_d;

  logic                bit_end;
  logic                next_bit;
  logic [NUM_BITS-1:0] shifted;

  assign bit_end = (cnt_q == CNT_LAST);

  // Vacated positions fill with ones so an exhausted register reads as idle line.
  always_comb begin
    if (SHIFT_MSB != 0) begin
      next_bit = shift_q[NUM_BITS-1];
      shifted  = {shift_q[NUM_BITS-2:0], 1'b1};
    end else begin
      next_bit = shift_q[0];
      shifted  = {1'b1, shift_q[NUM_BITS-1:1]};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    serial_d = serial_q;
    done_d   = 1'b0;

    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.tx_valid && ready_q) begin
          state_d  = START;
          shift_d  = bus.tx_data;
          par_d    = (PARITY_MODE == 2) ? ~(^bus.tx_data) : ^bus.tx_data;
          serial_d = 1'b0;
          cnt_d    = '0;
          bit_d    = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d  = DATA;
          serial_d = next_bit;
          shift_d  = shifted;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
            if (PARITY_MODE != 0) begin
              state_d  = PARITY;
              serial_d = par_q;
            end else begin
              state_d  = STOP;
              serial_d = 1'b1;
            end
          end else begin
            bit_d    = bit_q + 1'b1;
            serial_d = next_bit;
            shift_d  = shifted;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d  = STOP;
          serial_d = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
            bit_d   = '0;
            shift_d = '1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        serial_d = 1'b1;
        cnt_d    = '0;
        bit_d    = '0;
        shift_d  = '1;
      end
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '1;
      par_q    <= 1'b0;
      serial_q <= 1'b1;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      serial_q <= serial_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.serial_out = serial_q;
  assign bus.tx_ready   = ready_q;
  assign bus.busy       = ~ready_q;
  assign bus.tx_done    = done_q;

endmodule

// File: tb/tb_flex_serial_tx.sv
// Bench for flex_serial_tx: five parameter sets, frames checked cycle by cycle
// against a line waveform built from the framing rules.
module tb_flex_serial_tx;

  logic        clk;
  logic        n_rst;
  logic        drv_valid;
  logic [15:0] drv_data;
  int          sel;
  int          checks;
  int          errors;

  int p_n   [5];
  int p_msb [5];
  int p_cpb [5];
  int p_pm  [5];
  int p_sb  [5];

  bit exp_q [$];

  flex_serial_tx_if #(.NUM_BITS(8)) if0 ();
  flex_serial_tx_if #(.NUM_BITS(8)) if1 ();
  flex_serial_tx_if #(.NUM_BITS(8)) if2 ();
  flex_serial_tx_if #(.NUM_BITS(8)) if3 ();
  flex_serial_tx_if #(.NUM_BITS(2)) if4 ();

  assign if0.tx_data  = drv_data[7:0];
  assign if1.tx_data  = drv_data[7:0];
  assign if2.tx_data  = drv_data[7:0];
  assign if3.tx_data  = drv_data[7:0];
  assign if4.tx_data  = drv_data[1:0];
  assign if0.tx_valid = drv_valid && (sel == 0);
  assign if1.tx_valid = drv_valid && (sel == 1);
  assign if2.tx_valid = drv_valid && (sel == 2);
  assign if3.tx_valid = drv_valid && (sel == 3);
  assign if4.tx_valid = drv_valid && (sel == 4);

  flex_serial_tx #(.NUM_BITS(8), .SHIFT_MSB(0), .CLKS_PER_BIT(4), .PARITY_MODE(0), .STOP_BITS(1))
    u0 (.clk(clk), .n_rst(n_rst), .bus(if0));
  flex_serial_tx #(.NUM_BITS(8), .SHIFT_MSB(1), .CLKS_PER_BIT(4), .PARITY_MODE(0), .STOP_BITS(1))
    u1 (.clk(clk), .n_rst(n_rst), .bus(if1));
  flex_serial_tx #(.NUM_BITS(8), .SHIFT_MSB(0), .CLKS_PER_BIT(4), .PARITY_MODE(1), .STOP_BITS(2))
    u2 (.clk(clk), .n_rst(n_rst), .bus(if2));
  flex_serial_tx #(.NUM_BITS(8), .SHIFT_MSB(0), .CLKS_PER_BIT(4), .PARITY_MODE(2), .STOP_BITS(2))
    u3 (.clk(clk), .n_rst(n_rst), .bus(if3));
  flex_serial_tx #(.NUM_BITS(2), .SHIFT_MSB(0), .CLKS_PER_BIT(1), .PARITY_MODE(0), .STOP_BITS(1))
    u4 (.clk(clk), .n_rst(n_rst), .bus(if4));

  logic m_so, m_rdy, m_busy, m_done;

  always_comb begin
    m_so = 1'bx; m_rdy = 1'bx; m_busy = 1'bx; m_done = 1'bx;
    case (sel)
      0: begin m_so = if0.serial_out; m_rdy = if0.tx_ready; m_busy = if0.busy; m_done = if0.tx_done; end
      1: begin m_so = if1.serial_out; m_rdy = if1.tx_ready; m_busy = if1.busy; m_done = if1.tx_done; end
      2: begin m_so = if2.serial_out; m_rdy = if2.tx_ready; m_busy = if2.busy; m_done = if2.tx_done; end
      3: begin m_so = if3.serial_out; m_rdy = if3.tx_ready; m_busy = if3.busy; m_done = if3.tx_done; end
      4: begin m_so = if4.serial_out; m_rdy = if4.tx_ready; m_busy = if4.busy; m_done = if4.tx_done; end
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level for every cycle of a frame, from the framing rules.
  task automatic build_exp(input int k, input logic [15:0] d);
    bit b;
    bit par;
    exp_q.delete();
    for (int c = 0; c < p_cpb[k]; c++) exp_q.push_back(1'b0);
    par = 1'b0;
    for (int j = 0; j < p_n[k]; j++) begin
      b = (p_msb[k] != 0) ? d[p_n[k]-1-j] : d[j];
      par = par ^ d[j];
      for (int c = 0; c < p_cpb[k]; c++) exp_q.push_back(b);
    end
    if (p_pm[k] != 0) begin
      b = (p_pm[k] == 2) ? ~par : par;
      for (int c = 0; c < p_cpb[k]; c++) exp_q.push_back(b);
    end
    for (int c = 0; c < p_sb[k] * p_cpb[k]; c++) exp_q.push_back(1'b1);
  endtask

  // Call at a negedge with the selected DUT idle. Ends at the tx_done cycle
  // (hold=1, valid left high) or one idle cycle later (hold=0).
  task automatic run_frame(input int k, input logic [15:0] d, input bit hold);
    int len;
    sel = k;
    build_exp(k, d);
    len = exp_q.size();
    #1;
    checks++;
    if (m_rdy !== 1'b1) begin
      errors++; $display("FAIL ready_before_frame k=%0d got %b exp 1", k, m_rdy);
    end
    drv_data  = d;
    drv_valid = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < len; i++) begin
      if (!hold) drv_valid = 1'($urandom_range(0, 1));
      drv_data = 16'($urandom);
      @(negedge clk);
      checks++;
      if (m_so !== exp_q[i]) begin
        errors++;
        $display("FAIL serial_out k=%0d data=%h cycle=%0d got %b exp %b", k, d, i, m_so, exp_q[i]);
      end
      checks++;
      if (m_rdy !== 1'b0 || m_busy !== 1'b1 || m_done !== 1'b0) begin
        errors++;
        $display("FAIL in_frame_flags k=%0d cycle=%0d got rdy=%b busy=%b done=%b exp 0 1 0",
                 k, i, m_rdy, m_busy, m_done);
      end
    end
    drv_valid = hold;
    @(negedge clk);
    checks++;
    if (m_done !== 1'b1 || m_rdy !== 1'b1 || m_busy !== 1'b0 || m_so !== 1'b1) begin
      errors++;
      $display("FAIL done_cycle k=%0d data=%h got done=%b rdy=%b busy=%b so=%b exp 1 1 0 1",
               k, d, m_done, m_rdy, m_busy, m_so);
    end
    if (!hold) begin
      @(negedge clk);
      checks++;
      if (m_done !== 1'b0 || m_rdy !== 1'b1 || m_so !== 1'b1) begin
        errors++;
        $display("FAIL after_done k=%0d got done=%b rdy=%b so=%b exp 0 1 1", k, m_done, m_rdy, m_so);
      end
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 5; k++) begin
      sel = k;
      #1;
      checks++;
      if (m_so !== 1'b1 || m_rdy !== 1'b1 || m_busy !== 1'b0 || m_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs k=%0d got so=%b rdy=%b busy=%b done=%b exp 1 1 0 0",
                 k, m_so, m_rdy, m_busy, m_done);
      end
    end
    sel = 0;
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_frame(0, 16'h00A5, 1'b0);
    for (int r = 0; r < 5; r++) run_frame(0, 16'($urandom_range(0, 255)), 1'b0);
  endtask

  task automatic test_msb_first();
    run_frame(1, 16'h0001, 1'b0);
    for (int r = 0; r < 4; r++) run_frame(1, 16'($urandom_range(0, 255)), 1'b0);
  endtask

  task automatic test_parity_stop();
    run_frame(2, 16'h00A5, 1'b0);
    run_frame(3, 16'h00A5, 1'b0);
    for (int r = 0; r < 3; r++) begin
      run_frame(2, 16'($urandom_range(0, 255)), 1'b0);
      run_frame(3, 16'($urandom_range(0, 255)), 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    run_frame(0, 16'h000F, 1'b1);
    run_frame(0, 16'h00F0, 1'b0);
    run_frame(2, 16'($urandom_range(0, 255)), 1'b1);
    run_frame(2, 16'($urandom_range(0, 255)), 1'b1);
    run_frame(2, 16'($urandom_range(0, 255)), 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    sel = 0;
    build_exp(0, 16'h0037);
    drv_data  = 16'h0037;
    drv_valid = 1'b1;
    @(posedge clk); #1;
    drv_valid = 1'b0;
    // cycles 16..19 carry data bit 3, which is 0 for 0x37
    for (int i = 0; i < 18; i++) begin
      drv_data = 16'($urandom);
      @(negedge clk);
      checks++;
      if (m_so !== exp_q[i]) begin
        errors++; $display("FAIL pre_abort_serial cycle=%0d got %b exp %b", i, m_so, exp_q[i]);
      end
    end
    #3;
    n_rst = 1'b0;
    #1;
    checks++;
    if (m_so !== 1'b1 || m_rdy !== 1'b1 || m_busy !== 1'b0 || m_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_async got so=%b rdy=%b busy=%b done=%b exp 1 1 0 0", m_so, m_rdy, m_busy, m_done);
    end
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (m_done !== 1'b0 || m_so !== 1'b1 || m_rdy !== 1'b1) begin
        errors++;
        $display("FAIL post_abort_idle cycle=%0d got done=%b so=%b rdy=%b exp 0 1 1", i, m_done, m_so, m_rdy);
      end
    end
    run_frame(0, 16'($urandom_range(0, 255)), 1'b0);
  endtask

  task automatic test_min_period();
    run_frame(4, 16'h0002, 1'b0);
    for (int r = 0; r < 4; r++) run_frame(4, 16'($urandom_range(0, 3)), 1'b1);
    run_frame(4, 16'($urandom_range(0, 3)), 1'b0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    n_rst     = 1'b0;
    drv_valid = 1'b0;
    drv_data  = '0;
    sel       = 0;
    p_n   = '{8, 8, 8, 8, 2};
    p_msb = '{0, 1, 0, 0, 0};
    p_cpb = '{4, 4, 4, 4, 1};
    p_pm  = '{0, 0, 1, 2, 0};
    p_sb  = '{1, 1, 2, 2, 1};
    @(negedge clk);
    test_reset();
    test_basic();
    test_msb_first();
    test_parity_stop();
    test_back_to_back();
    test_reset_mid_frame();
    test_min_period();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
